instruction_decode: RTL

Decode stage of the 5-stage pipeline, directly downstream of instruction fetch. It holds the IF/ID pipeline register, the 32x32 register file, the main/ALU control decoder, early branch/jump resolution, and load-use/branch hazard detection. It returns `PCSrcD`, `PCbranchD` and `hazardDetected` to fetch and drives decoded operands and controls to execute.

---
 rtl/instruction_decode.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/instruction_decode.sv
// instruction_decode
//   Decode stage of the 5-stage pipeline. Holds the IF/ID register, the 32x32
//   register file, the main/ALU control decoder, early branch/jump resolution
//   and load-use / branch hazard detection.
//
// Build option:
//   DECODE_WB_BYPASS_EN - when defined, a writeback to the register being read
//                         is forwarded to rd1D/rd2D in the same cycle. When not
//                         defined, reads return the pre-write value.
//
// Ports:
//   clk, reset              - rising-edge clock, synchronous active-high reset
//   instrF, pcPlus4F        - instruction and PC+4 from fetch
//   memReadE, regWriteE,
//   writeRegE               - load / register-write status of the E-stage instr
//   memToRegM, writeRegM    - load status of the M-stage instr
//   regWriteW, writeRegW,
//   resultW                 - register file write port
//   PCSrcD, PCbranchD       - redirect request and target back to fetch
//   hazardDetected          - stall fetch and IF/ID
//   rd1D, rd2D, signImmD,
//   rsD, rtD, rdD           - decoded operands and register fields
//   regWriteD, memToRegD, memWriteD, aluSrcD, regDstD, aluControlD
//                           - execute-stage controls
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrF,
  input  logic [31:0] pcPlus4F,
  input  logic        memReadE,
  input  logic        regWriteE,
  input  logic [4:0]  writeRegE,
  input  logic        memToRegM,
  input  logic [4:0]  writeRegM,
  input  logic        regWriteW,
  input  logic [4:0]  writeRegW,
  input  logic [31:0] resultW,
  output logic        PCSrcD,
  output logic [31:0] PCbranchD,
  output logic        hazardDetected,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [31:0] signImmD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rdD,
  output logic        regWriteD,
  output logic        memToRegD,
  output logic        memWriteD,
  output logic        aluSrcD,
  output logic        regDstD,
  output logic [2:0]  aluControlD
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] instrD;
  logic [31:0] pcPlus4D;
  logic        validD;

  logic [31:0] regs [32];

  logic [5:0]  op;
  logic [5:0]  funct;

  logic        reg_write_raw;
  logic        mem_to_reg_raw;
  logic        mem_write_raw;

  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        is_branch;
  logic        reads_rt;
  logic        taken;

  logic        load_use;
  logic        branch_on_e;
  logic        branch_on_m;

  // ---------------- IF/ID pipeline register ----------------
  // pcPlus4D is left alone on a flush; validD=0 already marks the slot dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      instrD   <= '0;
      pcPlus4D <= '0;
      validD   <= 1'b0;
    end else if (!hazardDetected) begin
      if (PCSrcD) begin
        instrD <= '0;
        validD <= 1'b0;
      end else begin
        instrD   <= instrF;
        pcPlus4D <= pcPlus4F;
        validD   <= 1'b1;
      end
    end
  end

  // ---------------- Register file ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (regWriteW && (writeRegW != 5'd0)) begin
      regs[writeRegW] <= resultW;
    end
  end

  // ---------------- Field extraction ----------------
  assign op       = instrD[31:26];
  assign funct    = instrD[5:0];
  assign rsD      = instrD[25:21];
  assign rtD      = instrD[20:16];
  assign rdD      = instrD[15:11];
  assign signImmD = {{16{instrD[15]}}, instrD[15:0]};

  always_comb begin
    rd1D = (rsD == 5'd0) ? 32'd0 : regs[rsD];
    rd2D = (rtD == 5'd0) ? 32'd0 : regs[rtD];
`ifdef DECODE_WB_BYPASS_EN
    if (regWriteW && (writeRegW != 5'd0) && (writeRegW == rsD)) rd1D = resultW;
    if (regWriteW && (writeRegW != 5'd0) && (writeRegW == rtD)) rd2D = resultW;
`endif
  end

  // ---------------- Main / ALU control decode ----------------
  always_comb begin
    reg_write_raw  = 1'b0;
    mem_to_reg_raw = 1'b0;
    mem_write_raw  = 1'b0;
    aluSrcD        = 1'b0;
    regDstD        = 1'b0;
    aluControlD    = 3'b000;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          6'b100000: begin reg_write_raw = 1'b1; regDstD = 1'b1; aluControlD = 3'b010; end
          6'b100010: begin reg_write_raw = 1'b1; regDstD = 1'b1; aluControlD = 3'b110; end
          6'b100100: begin reg_write_raw = 1'b1; regDstD = 1'b1; aluControlD = 3'b000; end
          6'b100101: begin reg_write_raw = 1'b1; regDstD = 1'b1; aluControlD = 3'b001; end
          6'b101010: begin reg_write_raw = 1'b1; regDstD = 1'b1; aluControlD = 3'b111; end
          default: ;
        endcase
      end
      OP_LW: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = 1'b1;
        aluSrcD        = 1'b1;
        aluControlD    = 3'b010;
      end
      OP_SW: begin
        mem_write_raw = 1'b1;
        aluSrcD       = 1'b1;
        aluControlD   = 3'b010;
      end
      OP_ADDI: begin
        reg_write_raw = 1'b1;
        aluSrcD       = 1'b1;
        aluControlD   = 3'b010;
      end
      default: ;
    endcase
  end

  // Bubble into E: only the state-changing controls need killing.
  assign regWriteD = reg_write_raw  && validD && !hazardDetected;
  assign memToRegD = mem_to_reg_raw && validD && !hazardDetected;
  assign memWriteD = mem_write_raw  && validD && !hazardDetected;

  // ---------------- Branch / jump resolution ----------------
  assign is_beq    = (op == OP_BEQ);
  assign is_bne    = (op == OP_BNE);
  assign is_j      = (op == OP_J);
  assign is_branch = is_beq || is_bne;

  assign taken = (is_beq && (rd1D == rd2D)) ||
                 (is_bne && (rd1D != rd2D)) ||
                 is_j;

  assign PCbranchD = is_j ? {pcPlus4D[31:28], instrD[25:0], 2'b00}
                          : pcPlus4D + {signImmD[29:0], 2'b00};

  assign PCSrcD = taken && validD && !hazardDetected;

  // ---------------- Hazard detection ----------------
  assign reads_rt = (op == OP_RTYPE) || (op == OP_SW) || is_branch;

  assign load_use = memReadE && (writeRegE != 5'd0) &&
                    ((writeRegE == rsD) || (reads_rt && (writeRegE == rtD)));

  assign branch_on_e = is_branch && regWriteE && (writeRegE != 5'd0) &&
                       ((writeRegE == rsD) || (writeRegE == rtD));

  assign branch_on_m = is_branch && memToRegM && (writeRegM != 5'd0) &&
                       ((writeRegM == rsD) || (writeRegM == rtD));

  assign hazardDetected = validD && (load_use || branch_on_e || branch_on_m);

endmodule
